// File: rtl/klein_pkg.sv
// Shared KLEIN decryption-stage definitions: S-box table, FSM encoding, state geometry.
package klein_pkg;

   localparam int STATE_W  = 64;
   localparam int ROT_BITS = 16;

   localparam logic [3:0] KLEIN_SBOX [16] = '{
      4'h7, 4'h4, 4'hA, 4'h9, 4'h1, 4'hF, 4'hB, 4'h0,
      4'hC, 4'h3, 4'h2, 4'h6, 4'h8, 4'hE, 4'hD, 4'h5
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/klein_sbox.sv
// KLEIN 4-bit S-box lookup (involutive, so it also serves as the inverse).
// Latency: combinational. Backpressure: none.
// Flow control: none; pure function of the input nibble.
module klein_sbox
   import klein_pkg::*;
(
   input  logic [3:0] nib_i,
   output logic [3:0] nib_o
);

   assign nib_o = KLEIN_SBOX[nib_i];

endmodule

// File: rtl/klein_inv_rot_sub.sv
// Inverse RotateNibbles (rotr16) then iterative inverse SubNibbles over 64-bit state.
// Latency: 16/NIB_PER_CYC cycles from acceptance to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready low while BUSY.
module klein_inv_rot_sub
   import klein_pkg::*;
#(
   parameter int NIB_PER_CYC = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [63:0]   in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [63:0]   out_data,
   output logic          busy
);

   localparam int NGRP  = 16 / NIB_PER_CYC;
   localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam int GW    = 4 * NIB_PER_CYC;

   if (!(NIB_PER_CYC == 1 || NIB_PER_CYC == 2 || NIB_PER_CYC == 4 ||
         NIB_PER_CYC == 8 || NIB_PER_CYC == 16)) begin : g_bad_param
      $error("klein_inv_rot_sub: NIB_PER_CYC must be 1, 2, 4, 8 or 16");
   end

   state_e               state_q, state_d;
   logic [STATE_W-1:0]   st_q, st_d;
   logic [GRP_W-1:0]     grp_q, grp_d;
   logic [GW-1:0]        sel_dat;
   logic [GW-1:0]        sub_dat;
   logic                 accept;

   // Group 0 is the most significant slice of the state.
   always_comb begin
      sel_dat = '0;
      for (int k = 0; k < NGRP; k++) begin
         if (int'(grp_q) == k) begin
            sel_dat = st_q[STATE_W-1-k*GW -: GW];
         end
      end
   end

   for (genvar i = 0; i < NIB_PER_CYC; i++) begin : g_sbox
      klein_sbox u_sbox (
         .nib_i (sel_dat[i*4 +: 4]),
         .nib_o (sub_dat[i*4 +: 4])
      );
   end

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == BUSY);
   assign out_data  = st_q;

   always_comb begin
      state_d = state_q;
      st_d    = st_q;
      grp_d   = grp_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               st_d    = {in_data[ROT_BITS-1:0], in_data[STATE_W-1:ROT_BITS]};
               grp_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            for (int k = 0; k < NGRP; k++) begin
               if (int'(grp_q) == k) begin
                  st_d[STATE_W-1-k*GW -: GW] = sub_dat;
               end
            end
            if (int'(grp_q) == NGRP - 1) begin
               grp_d   = '0;
               state_d = DONE;
            end else begin
               grp_d   = grp_q + GRP_W'(1);
            end
         end
         DONE: begin
            // Output handshake and a new load may share the same edge.
            if (out_ready) begin
               if (in_valid) begin
                  st_d    = {in_data[ROT_BITS-1:0], in_data[STATE_W-1:ROT_BITS]};
                  grp_d   = '0;
                  state_d = BUSY;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         st_q    <= '0;
         grp_q   <= '0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         grp_q   <= grp_d;
      end
   end

endmodule
